// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared state encoding and default constants for the memory stage.
package mem_stage_pkg;
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} mem_state_t;
    localparam int DEF_ADDR_BASE   = 1024;
    localparam int DEF_WAIT_CYCLES = 3;
    localparam int SRAM_DW         = 16;
endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: sequences one 32-bit word as two wait-stated 16-bit SRAM transfers.
module sram_ctrl import mem_stage_pkg::*; #(
    parameter int Width       = 32,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int SRAM_AW     = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd,
    input  logic                 wr,
    input  logic [SRAM_AW-2:0]   word,
    input  logic [Width-1:0]     wdata,
    output logic [Width-1:0]     rdata,
    output logic                 freeze,
    output logic [SRAM_AW-1:0]   sram_addr,
    output logic                 sram_we_n,
    output logic [SRAM_DW-1:0]   sram_dq_out,
    output logic                 sram_dq_oe,
    input  logic [SRAM_DW-1:0]   sram_dq_in
);
    localparam int CW = $clog2(WAIT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);

    mem_state_t         state;
    logic [CW-1:0]      cnt;
    logic [SRAM_DW-1:0] lo_q;
    logic               req, wr_only, active, last;

    assign req     = rd | wr;
    assign wr_only = wr & ~rd;
    assign active  = req & (state == LO || state == HI);
    assign last    = cnt == '0;
    assign freeze  = req & (state != DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            lo_q  <= '0;
            rdata <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    state <= LO;
                    cnt   <= CNT_INIT;
                end
                LO: if (!req) state <= IDLE;
                else if (last) begin
                    state <= HI;
                    cnt   <= CNT_INIT;
                    if (rd) lo_q <= sram_dq_in;
                end else cnt <= cnt - CW'(1);
                HI: if (!req) state <= IDLE;
                else if (last) begin
                    state <= DONE;
                    if (rd) rdata <= Width'({sram_dq_in, lo_q});
                end else cnt <= cnt - CW'(1);
                default: state <= IDLE;
            endcase
        end
    end

    // pins decode from the registered state, so a dropped request stops the strobe at once
    always_comb begin
        sram_addr   = active ? {word, state == HI} : '0;
        sram_dq_oe  = active & wr_only;
        sram_we_n   = ~sram_dq_oe;
        sram_dq_out = !sram_dq_oe ? '0 : state == HI ? wdata[2*SRAM_DW-1:SRAM_DW] : wdata[SRAM_DW-1:0];
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage; passes EX/MEM fields through and maps loads/stores onto a 16-bit SRAM.
module mem_stage import mem_stage_pkg::*; #(
    parameter int Width       = 32,
    parameter int ADDR_BASE   = DEF_ADDR_BASE,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_enable_in,
    input  logic               mem_read_enable_in,
    input  logic               mem_write_enable_in,
    input  logic [Width-1:0]   alu_res_in,
    input  logic [Width-1:0]   val_rm_in,
    input  logic [3:0]         dest_in,
    output logic               wb_enable_out,
    output logic               mem_read_enable_out,
    output logic [Width-1:0]   alu_res_out,
    output logic [Width-1:0]   data_memory_out,
    output logic [3:0]         dest_out,
    output logic               freeze,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in
);
    logic [Width-1:0]   offset;
    logic [SRAM_AW-2:0] word;

    assign wb_enable_out       = wb_enable_in;
    assign mem_read_enable_out = mem_read_enable_in;
    assign alu_res_out         = alu_res_in;
    assign dest_out            = dest_in;
    assign offset              = alu_res_in - Width'(ADDR_BASE);
    assign word                = (SRAM_AW-1)'(offset >> 2);

    sram_ctrl #(
        .Width(Width),
        .WAIT_CYCLES(WAIT_CYCLES),
        .SRAM_AW(SRAM_AW)
    ) u_ctrl (
        .clk(clk),
        .rst(rst),
        .rd(mem_read_enable_in),
        .wr(mem_write_enable_in),
        .word(word),
        .wdata(val_rm_in),
        .rdata(data_memory_out),
        .freeze(freeze),
        .sram_addr(sram_addr),
        .sram_we_n(sram_we_n),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in)
    );
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage against a word-level memory model.
module tb_mem_stage;
    localparam int W  = 3;
    localparam int AB = 1024;

    logic        clk = 0, rst = 1;
    logic        wb_enable_in = 0, mem_read_enable_in = 0, mem_write_enable_in = 0;
    logic [31:0] alu_res_in = 0, val_rm_in = 0;
    logic [3:0]  dest_in = 0;
    logic        wb_enable_out, mem_read_enable_out, freeze, sram_we_n, sram_dq_oe;
    logic [31:0] alu_res_out, data_memory_out;
    logic [3:0]  dest_out;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;

    always #5 clk = ~clk;

    mem_stage #(.Width(32), .ADDR_BASE(AB), .WAIT_CYCLES(W), .SRAM_AW(18)) dut (
        .clk(clk), .rst(rst),
        .wb_enable_in(wb_enable_in), .mem_read_enable_in(mem_read_enable_in),
        .mem_write_enable_in(mem_write_enable_in), .alu_res_in(alu_res_in),
        .val_rm_in(val_rm_in), .dest_in(dest_in),
        .wb_enable_out(wb_enable_out), .mem_read_enable_out(mem_read_enable_out),
        .alu_res_out(alu_res_out), .data_memory_out(data_memory_out), .dest_out(dest_out),
        .freeze(freeze), .sram_addr(sram_addr), .sram_we_n(sram_we_n),
        .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
    );

    // reference memory (half-words) and the SRAM device model it is compared with
    logic [15:0] ref_mem [64];
    logic [15:0] sram_mem [64];
    logic        preload = 0;
    int          wcnt = 0;
    logic [17:0] waddr = '0;

    assign sram_dq_in = sram_mem[sram_addr[5:0]];

    // a half-word commits only after the strobe is held W cycles on one address
    always @(posedge clk) begin
        if (preload) for (int i = 0; i < 64; i++) sram_mem[i] <= ref_mem[i];
        else if (sram_we_n || !sram_dq_oe) wcnt <= 0;
        else begin
            wcnt  <= (wcnt != 0 && waddr == sram_addr) ? wcnt + 1 : 1;
            waddr <= sram_addr;
            if (((wcnt != 0 && waddr == sram_addr) ? wcnt + 1 : 1) == W)
                sram_mem[sram_addr[5:0]] <= sram_dq_out;
        end
    end

    typedef struct {
        logic        rd;
        logic        wr;
        int          w;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    int          total = 0, bad = 0, run = 0;
    logic        mon_en = 0;
    logic [31:0] last_rd = 0, exp_addr;
    logic        strobe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: checks every cycle, pops the scoreboard in the DONE cycle
    always @(negedge clk) begin
        if (rst) last_rd = 0;
        if (!mon_en) run = 0;
        else begin
            check("pass_alu", alu_res_out, alu_res_in);
            check("pass_dest", {28'd0, dest_out}, {28'd0, dest_in});
            check("pass_wb", {31'd0, wb_enable_out}, {31'd0, wb_enable_in});
            check("pass_mre", {31'd0, mem_read_enable_out}, {31'd0, mem_read_enable_in});
            if (!(mem_read_enable_in | mem_write_enable_in)) begin
                check("idle_freeze", {31'd0, freeze}, 0);
                check("idle_we_n", {31'd0, sram_we_n}, 1);
                check("idle_oe", {31'd0, sram_dq_oe}, 0);
                check("hold_rdata", data_memory_out, last_rd);
                run = 0;
            end else if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: got request with no expectation at %0t", $time);
            end else if (freeze) begin
                exp_addr = run == 0 ? 0 : run <= W ? 2 * sbq[0].w : 2 * sbq[0].w + 1;
                strobe = sbq[0].wr && !sbq[0].rd && run > 0;
                check("sram_addr", {14'd0, sram_addr}, exp_addr);
                check("we_n", {31'd0, sram_we_n}, {31'd0, !strobe});
                check("oe", {31'd0, sram_dq_oe}, {31'd0, strobe});
                if (strobe) check("dq_out", {16'd0, sram_dq_out},
                                  {16'd0, run <= W ? sbq[0].data[15:0] : sbq[0].data[31:16]});
                run++;
            end else begin
                e = sbq.pop_front();
                check("freeze_len", run, 2 * W + 1);
                check("done_we_n", {31'd0, sram_we_n}, 1);
                check("done_addr", {14'd0, sram_addr}, 0);
                if (e.rd) begin
                    check("rdata", data_memory_out, e.data);
                    last_rd = e.data;
                end else check("wdata", {sram_mem[2 * e.w + 1], sram_mem[2 * e.w]}, e.data);
                run = 0;
            end
        end
    end

    task automatic access(input logic rd, input logic wr, input int w, input logic [31:0] wd, output int cyc);
        exp_t x;
        x.rd = rd;
        x.wr = wr;
        x.w  = w;
        if (rd) x.data = {ref_mem[2 * w + 1], ref_mem[2 * w]};
        else begin
            x.data = wd;
            ref_mem[2 * w]     = wd[15:0];
            ref_mem[2 * w + 1] = wd[31:16];
        end
        sbq.push_back(x);
        mem_read_enable_in  = rd;
        mem_write_enable_in = wr;
        alu_res_in          = AB + 4 * w;
        val_rm_in           = wd;
        wb_enable_in        = rd;
        dest_in             = 4'($urandom);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (freeze && cyc < 50);
        if (cyc >= 50) begin
            total++;
            bad++;
            $display("FAIL access_timeout: freeze still high after %0d cycles", cyc);
        end
        @(posedge clk);
        #1;
        mem_read_enable_in  = 0;
        mem_write_enable_in = 0;
    endtask

    task automatic idle_cycle();
        wb_enable_in = 1'($urandom);
        alu_res_in   = $urandom;
        dest_in      = 4'($urandom);
        @(posedge clk);
        #1;
    endtask

    int c1, c2;
    logic [1:0] op;

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 16'($urandom);
        ref_mem[2] = 16'hBEEF;
        ref_mem[3] = 16'hDEAD;
        preload = 1;
        repeat (3) @(posedge clk);
        #1;
        preload = 0;
        rst = 0;
        @(negedge clk);
        check("rst_freeze", {31'd0, freeze}, 0);
        check("rst_we_n", {31'd0, sram_we_n}, 1);
        check("rst_oe", {31'd0, sram_dq_oe}, 0);
        check("rst_addr", {14'd0, sram_addr}, 0);
        check("rst_rdata", data_memory_out, 0);

        @(posedge clk);
        #1;
        mon_en = 1;
        wb_enable_in = 1;
        alu_res_in   = 32'h55;
        dest_in      = 4'd7;
        @(negedge clk);
        check("alu_res", alu_res_out, 32'h55);
        check("alu_dest", {28'd0, dest_out}, 7);
        check("alu_freeze", {31'd0, freeze}, 0);
        @(posedge clk);
        #1;

        access(1, 0, 1, 0, c1);
        check("read_cycles", c1, 2 * W + 2);
        check("read_result", data_memory_out, 32'hDEADBEEF);
        access(0, 1, 0, 32'h12345678, c1);
        check("write_cycles", c1, 2 * W + 2);
        access(1, 0, 0, 0, c1);
        check("readback", data_memory_out, 32'h12345678);

        access(1, 0, 1, 0, c1);
        access(0, 1, 2, $urandom, c2);
        check("b2b_cycles", c1 + c2, 4 * W + 4);

        access(1, 1, 0, 32'hFFFF0000, c1);
        check("rw_both_result", data_memory_out, 32'h12345678);

        // write dropped after one LO cycle must leave memory untouched
        mon_en = 0;
        mem_write_enable_in = 1;
        alu_res_in = AB + 4 * 5;
        val_rm_in  = 32'hA5A55A5A;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        mem_write_enable_in = 0;
        @(negedge clk);
        check("flush_freeze", {31'd0, freeze}, 0);
        check("flush_we_n", {31'd0, sram_we_n}, 1);
        @(posedge clk);
        #1;
        mon_en = 1;
        access(1, 0, 5, 0, c1);
        check("flush_cycles", c1, 2 * W + 2);

        // reset in the 2nd HI cycle of a write aborts before the high half commits
        mon_en = 0;
        mem_write_enable_in = 1;
        alu_res_in = AB + 4 * 9;
        val_rm_in  = 32'hCAFEF00D;
        repeat (5) @(posedge clk);
        #1;
        rst = 1;
        @(negedge clk);
        check("rst_hi_addr", {14'd0, sram_addr}, 19);
        check("rst_hi_we_n", {31'd0, sram_we_n}, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_freeze", {31'd0, freeze}, 1);
        check("abort_we_n", {31'd0, sram_we_n}, 1);
        check("abort_oe", {31'd0, sram_dq_oe}, 0);
        check("abort_addr", {14'd0, sram_addr}, 0);
        check("abort_rdata", data_memory_out, 0);
        @(posedge clk);
        #1;
        rst = 0;
        mem_write_enable_in = 0;
        @(negedge clk);
        check("abort_idle_freeze", {31'd0, freeze}, 0);
        ref_mem[18] = 16'hF00D;
        @(posedge clk);
        #1;
        mon_en = 1;
        access(1, 0, 9, 0, c1);

        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) idle_cycle();
            op = 2'($urandom_range(0, 3));
            access(op != 1, op != 0, int'($urandom_range(0, 31)), $urandom, c1);
            check("rand_cycles", c1, 2 * W + 2);
        end
        idle_cycle();
        idle_cycle();
        check("sb_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the ARM-style pipeline, between the EX/MEM register and `mem_stage_reg`. Loads and stores go to an external 16-bit SRAM, so each 32-bit word takes two half-word transfers with programmable wait states. A small FSM sequences the transfers and raises `freeze` to stall the pipeline until the word completes. Non-memory instructions pass through with zero added latency.

## Interface
- `Width`, 32: datapath width (ALU result, store data, load data).
- `ADDR_BASE`, 1024: byte address mapped to SRAM half-word 0.
- `WAIT_CYCLES`, 3: cycles per half-word transfer, ≥1.
- `SRAM_AW`, 18: SRAM half-word address width.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous active-high reset.
- `wb_enable_in` input 1: writeback enable from EX/MEM.
- `mem_read_enable_in` input 1: load request.
- `mem_write_enable_in` input 1: store request.
- `alu_res_in` input Width: byte address, or ALU result.
- `val_rm_in` input Width: store data.
- `dest_in` input 4: destination register.
- `wb_enable_out` output 1: to `mem_stage_reg`.
- `mem_read_enable_out` output 1: to `mem_stage_reg`.
- `alu_res_out` output Width: to `mem_stage_reg`.
- `data_memory_out` output Width: load result, registered.
- `dest_out` output 4: to `mem_stage_reg`.
- `freeze` output 1: high stalls PC, IF/ID, ID/EX, EX/MEM, `mem_stage_reg`.
- `sram_addr` output SRAM_AW: half-word address.
- `sram_we_n` output 1: active-low write strobe.
- `sram_dq_out` output 16: write data.
- `sram_dq_oe` output 1: high drives `sram_dq_out` onto the bus.
- `sram_dq_in` input 16: read data from the bus.

## Operation
- `wb_enable`, `mem_read_enable`, `alu_res` and `dest` pass combinationally from input to output.
- Request: `req = mem_read_enable_in | mem_write_enable_in`.
- If both read and write are asserted, the access is a read and no write strobe is driven.
- Word index: `w = (alu_res_in - ADDR_BASE) >> 2`, truncated to SRAM_AW-1 bits.
- Low half-word address: `{w,0}`. High half-word address: `{w,1}`.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: if `req`, go to LO and load the wait counter to WAIT_CYCLES-1.
  - LO: drive `{w,0}`. When the counter reaches 0, go to HI and reload the counter.
  - HI: drive `{w,1}`. When the counter reaches 0, go to DONE.
  - DONE: always go to IDLE.
- Read: in the last LO cycle, capture `sram_dq_in` into `lo_q`. In the last HI cycle, load `data_memory_out <= {sram_dq_in, lo_q}`. The value holds until the next read completes.
- Write, LO: `sram_we_n=0`, `sram_dq_oe=1`, `sram_dq_out=val_rm_in[15:0]`.
- Write, HI: `sram_we_n=0`, `sram_dq_oe=1`, `sram_dq_out=val_rm_in[31:16]`.
- In IDLE and DONE: `sram_we_n=1`, `sram_dq_oe=0`, `sram_addr=0`.
- `freeze = req & (state != DONE)`. It is combinational, so it rises in the same cycle the request appears.
- Upstream holds the EX/MEM inputs stable while `freeze` is high.
- If `req` drops in LO or HI (flush): next state is IDLE. `data_memory_out` is not updated and no further write strobe is driven.
- A new request arriving in the IDLE cycle right after DONE starts immediately. Back-to-back accesses have no gap cycle.

## Timing
- Reset (synchronous): state IDLE, counter 0, `lo_q=0`, `data_memory_out=0`, `sram_we_n=1`, `sram_dq_oe=0`, `sram_addr=0`, `sram_dq_out=0`.
- `freeze` after reset is 0 unless `req` is high.
- A reset mid-access aborts: on the next edge all state returns to the reset values.
- Per access: IDLE 1 cycle, LO WAIT_CYCLES, HI WAIT_CYCLES, DONE 1 cycle, for 2·WAIT_CYCLES+2 cycles total.
- `freeze` is high for the first 2·WAIT_CYCLES+1 of those cycles.
- The pipeline advances on the edge that ends DONE. `mem_stage_reg` samples `data_memory_out`, which is valid throughout DONE.
- Non-memory instruction: 0 extra cycles, `freeze=0`.

## Structure
- `mem_stage_pkg`:
  - state enum `mem_state_t` (IDLE, LO, HI, DONE);
  - default constants for `ADDR_BASE` and `WAIT_CYCLES`;
  - the SRAM data width constant, 16.
- Counter width: `$clog2(WAIT_CYCLES)+1`.
- One sub-module, `sram_ctrl`: FSM, counter, `lo_q`, SRAM pins, `freeze`.
- `mem_stage` top: pass-through wiring and address computation.

## Test plan
- Reset, then idle inputs: `freeze=0`, `sram_we_n=1`, `sram_dq_oe=0`, `data_memory_out=0`.
- ALU instruction, `alu_res_in=0x55`, `dest_in=7`, `wb_enable_in=1`: outputs mirror the inputs the same cycle; `freeze=0`.
- Read at 1028, WAIT_CYCLES=3, SRAM model holds half-word 2=0xBEEF and 3=0xDEAD:
  - `sram_addr` is 2 for 3 cycles, then 3 for 3 cycles;
  - `freeze` is high for 7 cycles;
  - `data_memory_out=0xDEADBEEF` in DONE.
- Write 0x12345678 at 1024: `sram_we_n=0` for 6 cycles; half-word 0=0x5678, half-word 1=0x1234; a later read returns 0x12345678.
- Back-to-back read at 1028 then write at 1032: the second access starts in the cycle after DONE; 16 cycles total; no spurious strobe between accesses.
- Reset asserted in the 2nd HI cycle of a write: next cycle state IDLE, `sram_we_n=1`, `freeze` follows `req` only; half-word 1 is not written.
- Read and write both asserted: behaves as a read; `sram_we_n` stays 1.
